core_sequencer: RTL and testbench

//  Multi-cycle control FSM for the RV32I core. Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.

---
 rtl/core_seq_if.sv | 41 ++++
 rtl/core_sequencer.sv | 165 ++++++++++++++++
 tb/tb_core_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_if.sv
// Handshake/strobe bundle between core_sequencer and the rest of the RV32I core.
// SEQ_PERF_CNT_EN adds the cycle_cnt / instret_cnt performance counters.
interface core_seq_if;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       imem_req;
   logic       imem_ack;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ack;
   logic       ir_we;
   logic       rf_we;
   logic       pc_we;
   logic [1:0] pc_sel;
   logic       retire;
   logic       illegal;
   logic       bus_err;
   logic [2:0] state_o;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instret_cnt;
`endif

   modport master (
      input  opcode, branch_taken, imem_ack, dmem_ack,
      output imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel,
             retire, illegal, bus_err, state_o
`ifdef SEQ_PERF_CNT_EN
      , output cycle_cnt, instret_cnt
`endif
   );

   modport slave (
      output opcode, branch_taken, imem_ack, dmem_ack,
      input  imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel,
             retire, illegal, bus_err, state_o
`ifdef SEQ_PERF_CNT_EN
      , input cycle_cnt, instret_cnt
`endif
   );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I core.
// Optional SEQ_PERF_CNT_EN adds cycle and retired-instruction counters.
module core_sequencer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   core_seq_if.master bus
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
      MEM = 3'd4, WB = 3'd5, TRAP = 3'd6
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_MISC   = 7'b0001111;

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    opc_q, opc_d;
   logic          illegal_q, illegal_d;
   logic          bus_err_q, bus_err_d;

   logic       imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, retire;
   logic [1:0] pc_sel;
   logic       limit_hit;

   function automatic logic supported(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
         OP_STORE, OP_IMM, OP_OP, OP_MISC: supported = 1'b1;
         default:                          supported = 1'b0;
      endcase
   endfunction

   function automatic logic writes_rd(input logic [6:0] op);
      case (op)
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP: writes_rd = 1'b1;
         default:                                                   writes_rd = 1'b0;
      endcase
   endfunction

   // cnt_q counts completed wait cycles; this cycle would be number TIMEOUT
   assign limit_hit = (TIMEOUT != 0) && (32'(cnt_q) == TIMEOUT - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         opc_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         opc_q     <= opc_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = '0;
      opc_d     = opc_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'b00;
      retire    = 1'b0;
      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            imem_req = 1'b1;
            if (bus.imem_ack) begin
               ir_we   = 1'b1;
               state_d = DECODE;
            end else if (limit_hit) begin
               state_d   = TRAP;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DECODE: begin
            opc_d = bus.opcode;
            if (supported(bus.opcode)) begin
               state_d = EXEC;
            end else begin
               state_d   = TRAP;
               illegal_d = 1'b1;
            end
         end
         EXEC: state_d = (opc_q == OP_LOAD || opc_q == OP_STORE) ? MEM : WB;
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (opc_q == OP_STORE);
            if (bus.dmem_ack) begin
               state_d = WB;
            end else if (limit_hit) begin
               state_d   = TRAP;
               bus_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WB: begin
            retire  = 1'b1;
            pc_we   = 1'b1;
            rf_we   = writes_rd(opc_q);
            if (opc_q == OP_JAL || (opc_q == OP_BRANCH && bus.branch_taken))
               pc_sel = 2'b01;
            else if (opc_q == OP_JALR)
               pc_sel = 2'b10;
            state_d = FETCH;
         end
         TRAP:    state_d = TRAP;
         default: state_d = IDLE;
      endcase
   end

   assign bus.imem_req = imem_req;
   assign bus.dmem_req = dmem_req;
   assign bus.dmem_we  = dmem_we;
   assign bus.ir_we    = ir_we;
   assign bus.rf_we    = rf_we;
   assign bus.pc_we    = pc_we;
   assign bus.pc_sel   = pc_sel;
   assign bus.retire   = retire;
   assign bus.illegal  = illegal_q;
   assign bus.bus_err  = bus_err_q;
   assign bus.state_o  = state_q;

`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_q, instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_q   <= '0;
         instret_q <= '0;
      end else begin
         if (state_q != IDLE && state_q != TRAP) cycle_q <= cycle_q + 32'd1;
         if (retire)                            instret_q <= instret_q + 32'd1;
      end
   end

   assign bus.cycle_cnt   = cycle_q;
   assign bus.instret_cnt = instret_q;
`endif
endmodule

// File: tb/tb_core_sequencer.sv
// Directed vector bench for core_sequencer: table of instructions plus trap/timeout/reset sequences.
module tb_core_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   core_seq_if bif ();

   core_sequencer #(.TIMEOUT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] op;
      logic       tk;
      int         mw;
      int         rf;
      int         sel;
      int         ret;
      int         dm_n;
      int         dm_we;
   } vec_t;

   typedef struct {
      int idle_n;
      int ir_rel;
      int ret_rel;
      int trap_rel;
      int rf;
      int sel;
      int pcwe;
      int dm_n;
      int dm_we;
      int im_n;
      int sel_bad;
      int rf_bad;
      int to;
   } rec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      bif.imem_ack = 1'b0;
      bif.dmem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Acts as zero/fixed-wait memory; cycle numbers are relative to FETCH entry (= 1).
   task automatic run_instr(input logic [6:0] op, input logic tk, input int fw,
                            input int mw, output rec_t r);
      int fc, mc, fetch_at;
      fc = 0; mc = 0; fetch_at = 0;
      r = '{default: 0};
      r.to = 1;
      bif.opcode = op;
      bif.branch_taken = tk;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         bif.imem_ack = bif.imem_req && (fc == fw);
         bif.dmem_ack = bif.dmem_req && (mc == mw);
         #1;
         if (bif.state_o == 3'd0) r.idle_n++;
         if (bif.state_o == 3'd1 && fetch_at == 0) fetch_at = cyc;
         if (bif.imem_req) begin fc++; r.im_n++; end
         if (bif.dmem_req) begin
            mc++; r.dm_n++;
            if (bif.dmem_we) r.dm_we = 1;
         end
         if (bif.ir_we) r.ir_rel = cyc - fetch_at + 1;
         if (bif.pc_sel != 2'b00 && !bif.pc_we) r.sel_bad++;
         if (bif.rf_we && !bif.retire) r.rf_bad++;
         if (bif.state_o == 3'd6) begin
            r.trap_rel = cyc - fetch_at + 1;
            r.to = 0;
            break;
         end
         if (bif.retire) begin
            r.ret_rel = cyc - fetch_at + 1;
            r.rf = 32'(bif.rf_we);
            r.sel = 32'(bif.pc_sel);
            r.pcwe = 32'(bif.pc_we);
         end
         @(posedge clk);
         #1;
         bif.imem_ack = 1'b0;
         bif.dmem_ack = 1'b0;
         if (r.ret_rel != 0) begin
            r.to = 0;
            break;
         end
      end
   endtask

   vec_t vecs[12];
   rec_t r;

   initial begin
      vecs[0]  = '{7'b0010011, 1'b0, 0, 1, 0, 4, 0, 0}; // addi
      vecs[1]  = '{7'b0100011, 1'b0, 3, 0, 0, 8, 4, 1}; // store, 3 waits
      vecs[2]  = '{7'b1100011, 1'b1, 0, 0, 1, 4, 0, 0}; // branch taken
      vecs[3]  = '{7'b1100011, 1'b0, 0, 0, 0, 4, 0, 0}; // branch not taken
      vecs[4]  = '{7'b0000011, 1'b0, 0, 1, 0, 5, 1, 0}; // load zero-wait
      vecs[5]  = '{7'b0000011, 1'b0, 2, 1, 0, 7, 3, 0}; // load 2 waits
      vecs[6]  = '{7'b0110111, 1'b0, 0, 1, 0, 4, 0, 0}; // lui
      vecs[7]  = '{7'b0010111, 1'b0, 0, 1, 0, 4, 0, 0}; // auipc
      vecs[8]  = '{7'b1101111, 1'b0, 0, 1, 1, 4, 0, 0}; // jal
      vecs[9]  = '{7'b1100111, 1'b1, 0, 1, 2, 4, 0, 0}; // jalr
      vecs[10] = '{7'b0110011, 1'b1, 0, 1, 0, 4, 0, 0}; // op, taken ignored
      vecs[11] = '{7'b0001111, 1'b0, 0, 0, 0, 4, 0, 0}; // fence

      bif.opcode = 7'd0;
      bif.branch_taken = 1'b0;
      bif.imem_ack = 1'b0;
      bif.dmem_ack = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", 32'(bif.state_o), 0);
      chk("rst_strobes", 32'({bif.imem_req, bif.dmem_req, bif.dmem_we, bif.ir_we,
                               bif.rf_we, bif.pc_we, bif.retire}), 0);
      chk("rst_pc_sel", 32'(bif.pc_sel), 0);
      chk("rst_flags", 32'({bif.illegal, bif.bus_err}), 0);
`ifdef SEQ_PERF_CNT_EN
      chk("rst_cycle_cnt", int'(bif.cycle_cnt), 0);
      chk("rst_instret_cnt", int'(bif.instret_cnt), 0);
`endif
      #1 rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_instr(vecs[i].op, vecs[i].tk, 0, vecs[i].mw, r);
         if (i == 0) chk("idle_cycles", r.idle_n, 1);
         chk($sformatf("v%0d_done", i), r.to, 0);
         chk($sformatf("v%0d_ir_cyc", i), r.ir_rel, 1);
         chk($sformatf("v%0d_ret_cyc", i), r.ret_rel, vecs[i].ret);
         chk($sformatf("v%0d_rf_we", i), r.rf, vecs[i].rf);
         chk($sformatf("v%0d_pc_sel", i), r.sel, vecs[i].sel);
         chk($sformatf("v%0d_pc_we", i), r.pcwe, 1);
         chk($sformatf("v%0d_dmem_cycles", i), r.dm_n, vecs[i].dm_n);
         chk($sformatf("v%0d_dmem_we", i), r.dm_we, vecs[i].dm_we);
         chk($sformatf("v%0d_sel_outside_wb", i), r.sel_bad, 0);
         chk($sformatf("v%0d_rf_outside_wb", i), r.rf_bad, 0);
      end
`ifdef SEQ_PERF_CNT_EN
      chk("instret_after_table", int'(bif.instret_cnt), 12);
`endif

      // ack on the 4th fetch cycle beats the timeout
      do_reset();
      run_instr(7'b0010011, 1'b0, 3, 0, r);
      chk("to_ack4_done", r.to, 0);
      chk("to_ack4_ret", r.ret_rel, 7);
      chk("to_ack4_im_cycles", r.im_n, 4);
      chk("to_ack4_bus_err", 32'(bif.bus_err), 0);

      // no ack: trap after 4 wait cycles
      run_instr(7'b0010011, 1'b0, 100, 0, r);
      chk("to_trap_cyc", r.trap_rel, 5);
      chk("to_trap_im_cycles", r.im_n, 4);
      chk("to_trap_bus_err", 32'(bif.bus_err), 1);
      chk("to_trap_illegal", 32'(bif.illegal), 0);
      chk("to_trap_imem_req", 32'(bif.imem_req), 0);

      // ecall -> illegal trap, stays quiet, reset clears
      do_reset();
      run_instr(7'b1110011, 1'b0, 0, 0, r);
      chk("ecall_trap_cyc", r.trap_rel, 3);
      chk("ecall_illegal", 32'(bif.illegal), 1);
      chk("ecall_bus_err", 32'(bif.bus_err), 0);
      begin
         int req_seen, rt_seen;
         req_seen = 0; rt_seen = 0;
         for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            bif.imem_ack = 1'b1;
            bif.dmem_ack = 1'b1;
            #1;
            if (bif.imem_req || bif.dmem_req) req_seen++;
            if (bif.retire || bif.pc_we || bif.ir_we) rt_seen++;
         end
         bif.imem_ack = 1'b0;
         bif.dmem_ack = 1'b0;
         chk("trap_no_req", req_seen, 0);
         chk("trap_no_strobe", rt_seen, 0);
         chk("trap_state_held", 32'(bif.state_o), 6);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_clears_illegal", 32'(bif.illegal), 0);

      // opcode[1:0] != 2'b11 is illegal too
      do_reset();
      run_instr(7'b0110001, 1'b0, 0, 0, r);
      chk("bad_low_bits_trap", r.trap_rel, 3);
      chk("bad_low_bits_illegal", 32'(bif.illegal), 1);

      // reset in the middle of a data access
      do_reset();
      bif.opcode = 7'b0000011;
      begin
         int hit;
         hit = 0;
         for (int i = 0; i < 20 && hit == 0; i++) begin
            @(negedge clk);
            bif.imem_ack = bif.imem_req;
            #1;
            if (bif.dmem_req) hit = 1;
            else begin
               @(posedge clk);
               #1 bif.imem_ack = 1'b0;
            end
         end
         chk("mid_mem_reached", hit, 1);
      end
      bif.imem_ack = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("mid_mem_req_drop", 32'(bif.dmem_req), 0);
      chk("mid_mem_state", 32'(bif.state_o), 0);
`ifdef SEQ_PERF_CNT_EN
      chk("mid_mem_cycle_cnt", int'(bif.cycle_cnt), 0);
      chk("mid_mem_instret_cnt", int'(bif.instret_cnt), 0);
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("post_rst_idle", 32'(bif.state_o), 0);
      @(posedge clk);
      #1;
      chk("post_rst_fetch", 32'(bif.state_o), 1);
      chk("post_rst_imem_req", 32'(bif.imem_req), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
